// File: rtl/rv64g_pkg.sv
// Shared RV64 front-end types and constants used by the PC sequencer slice.
package rv64g_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } pc_seq_state_e;

    // Clears bits [1:0] by masking so every input bit is read.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/tmd_updown_counter.sv
// Up/down counter saturating at 0 and MAX; a decrement at 0 is ignored outright.
module tmd_updown_counter #(
    parameter  int MAX   = 4,
    localparam int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic dec_eff;
    logic inc_eff;

    assign dec_eff = dec_i && (count_o != '0);
    assign inc_eff = inc_i && ((count_o != MAX_C) || dec_eff);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (inc_eff && !dec_eff) begin
            count_o <= count_o + CNT_W'(1);
        end else if (dec_eff && !inc_eff) begin
            count_o <= count_o - CNT_W'(1);
        end
    end

    assign full_o = (count_o == MAX_C);

endmodule

// File: rtl/tmd_pc_sequencer.sv
// Fetch PC sequencer: holds the fetch PC, issues epoch-tagged fetch requests and
// filters wrong-path responses. Optional perf counters under TMD_PC_SEQ_PERF_EN.
module tmd_pc_sequencer
    import rv64g_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR    = RESET_VECTOR_DEFAULT,
    parameter int              MAX_OUTSTANDING = 4,
    parameter int              EPOCH_W         = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               redirect_valid_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    input  logic               pred_valid_i,
    input  logic [XLEN-1:0]    pred_pc_i,
    input  logic               halt_i,
    output logic               fetch_valid_o,
    output logic [XLEN-1:0]    fetch_pc_o,
    output logic [EPOCH_W-1:0] fetch_epoch_o,
    input  logic               fetch_ready_i,
    input  logic               rsp_valid_i,
    input  logic [EPOCH_W-1:0] rsp_epoch_i,
`ifdef TMD_PC_SEQ_PERF_EN
    output logic [31:0]        perf_redirect_cnt_o,
    output logic [31:0]        perf_stall_cnt_o,
`endif
    output logic               rsp_keep_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    pc_seq_state_e      state_q, state_d;
    logic [XLEN-1:0]    pc_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic [CNT_W-1:0]   outstanding;
    logic               full;
    logic               fire;
    logic               redirect_take;
    logic               stall;

    tmd_updown_counter #(.MAX(MAX_OUTSTANDING)) u_outstanding (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (fire),
        .dec_i   (rsp_valid_i),
        .count_o (outstanding),
        .full_o  (full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= BOOT;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = halt_i ? HALT : RUN;
            HALT:    state_d = halt_i ? HALT : RUN;
            default: state_d = BOOT;
        endcase
    end

    // Valid depends only on registered state and the redirect, never on ready.
    always_comb begin
        fetch_valid_o = (state_q == RUN) && (outstanding < CNT_W'(MAX_OUTSTANDING))
                        && !redirect_valid_i;
        stall         = (state_q == RUN) && ((fetch_valid_o && !fetch_ready_i) || full);
    end

    assign fire          = fetch_valid_o && fetch_ready_i;
    assign redirect_take = redirect_valid_i && (state_q != BOOT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= RESET_VECTOR;
            epoch_q <= '0;
        end else if (redirect_take) begin
            pc_q    <= align_pc(redirect_pc_i);
            epoch_q <= epoch_q + EPOCH_W'(1);
        end else if (fire) begin
            pc_q    <= pred_valid_i ? align_pc(pred_pc_i) : pc_q + XLEN'(4);
        end
    end

    assign fetch_pc_o    = pc_q;
    assign fetch_epoch_o = epoch_q;
    assign rsp_keep_o    = rsp_valid_i && (rsp_epoch_i == epoch_q) && !rst_i;

`ifdef TMD_PC_SEQ_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_redirect_cnt_o <= '0;
            perf_stall_cnt_o    <= '0;
        end else begin
            if (redirect_take && (perf_redirect_cnt_o != '1))
                perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
            if (stall && (perf_stall_cnt_o != '1))
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = stall;
`endif

endmodule

// File: tb/tb_tmd_pc_sequencer.sv
// Scoreboard bench for tmd_pc_sequencer: a cycle-level reference model feeds
// expectation queues that an independent negedge monitor drains and compares.
module tb_tmd_pc_sequencer;
    import rv64g_pkg::*;

    localparam int MAX_OUT = 4;
    localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        pred_valid_i = 1'b0;
    logic [63:0] pred_pc_i = '0;
    logic        halt_i = 1'b0;
    logic        fetch_valid_o;
    logic [63:0] fetch_pc_o;
    logic [1:0]  fetch_epoch_o;
    logic        fetch_ready_i = 1'b0;
    logic        rsp_valid_i = 1'b0;
    logic [1:0]  rsp_epoch_i = '0;
    logic        rsp_keep_o;
`ifdef TMD_PC_SEQ_PERF_EN
    logic [31:0] perf_redirect_cnt_o;
    logic [31:0] perf_stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    tmd_pc_sequencer dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pred_valid_i     (pred_valid_i),
        .pred_pc_i        (pred_pc_i),
        .halt_i           (halt_i),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_epoch_o    (fetch_epoch_o),
        .fetch_ready_i    (fetch_ready_i),
        .rsp_valid_i      (rsp_valid_i),
        .rsp_epoch_i      (rsp_epoch_i),
`ifdef TMD_PC_SEQ_PERF_EN
        .perf_redirect_cnt_o (perf_redirect_cnt_o),
        .perf_stall_cnt_o    (perf_stall_cnt_o),
`endif
        .rsp_keep_o       (rsp_keep_o)
    );

    typedef struct { bit valid; bit keep; logic [63:0] pc; logic [1:0] ep; } cyc_exp_t;
    typedef struct { logic [63:0] pc; logic [1:0] ep; } req_exp_t;

    cyc_exp_t cyc_q[$];
    req_exp_t req_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: PC, epoch, number of requests in flight, cycles since reset.
    logic [63:0] m_pc;
    int          m_epoch;
    int          m_out;
    int          m_cyc;
    bit          m_prev_halt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RV;
        m_epoch = 0;
        m_out = 0;
        m_cyc = 0;
        m_prev_halt = 1'b0;
    endtask

    // Drive one cycle of inputs, record what the sequencer must show, then advance.
    task automatic step(input bit rdy, input bit pv, input logic [63:0] ppc,
                        input bit rd, input logic [63:0] rpc, input bit hl,
                        input bit rs, input logic [1:0] rse);
        bit running, exp_valid, fire;
        cyc_exp_t e;
        req_exp_t r;
        fetch_ready_i = rdy; pred_valid_i = pv; pred_pc_i = ppc;
        redirect_valid_i = rd; redirect_pc_i = rpc; halt_i = hl;
        rsp_valid_i = rs; rsp_epoch_i = rse;

        running   = (m_cyc == 1) || (m_cyc >= 2 && !m_prev_halt);
        exp_valid = running && (m_out < MAX_OUT) && !rd;
        fire      = exp_valid && rdy;
        e.valid = exp_valid;
        e.keep  = rs && (rse == 2'(m_epoch));
        e.pc    = m_pc;
        e.ep    = 2'(m_epoch);
        cyc_q.push_back(e);
        if (fire) begin
            r.pc = m_pc; r.ep = 2'(m_epoch);
            req_q.push_back(r);
        end

        if (m_cyc >= 1 && rd) begin
            m_pc = {rpc[63:2], 2'b00};
            m_epoch = (m_epoch + 1) % 4;
        end else if (fire && pv) begin
            m_pc = {ppc[63:2], 2'b00};
        end else if (fire) begin
            m_pc = m_pc + 64'd4;
        end
        m_out = m_out + (fire ? 1 : 0) - ((rs && m_out > 0) ? 1 : 0);
        m_prev_halt = hl;
        m_cyc++;

        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        fetch_ready_i = 1'b0; pred_valid_i = 1'b0; redirect_valid_i = 1'b0; halt_i = 1'b0;
        rsp_valid_i = 1'b1; rsp_epoch_i = 2'd0;
        @(posedge clk_i);
        #1;
        check("rst_valid", 64'(fetch_valid_o), 64'd0);
        check("rst_pc", fetch_pc_o, RV);
        check("rst_epoch", 64'(fetch_epoch_o), 64'd0);
        check("rst_keep", 64'(rsp_keep_o), 64'd0);
        rst_i = 1'b0;
        rsp_valid_i = 1'b0;
        model_reset();
    endtask

    function automatic bit auto_rsp();
        return m_out > 0;
    endfunction

    // Monitor: compare every cycle's outputs and every accepted request against the queues.
    cyc_exp_t mon_e;
    req_exp_t mon_r;
    always @(negedge clk_i) begin
        if (cyc_q.size() != 0) begin
            mon_e = cyc_q.pop_front();
            check("valid", 64'(fetch_valid_o), 64'(mon_e.valid));
            check("keep", 64'(rsp_keep_o), 64'(mon_e.keep));
            check("pc", fetch_pc_o, mon_e.pc);
            check("epoch", 64'(fetch_epoch_o), 64'(mon_e.ep));
        end
        if (fetch_valid_o && fetch_ready_i && !rst_i) begin
            if (req_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL req_unexpected: got request pc %h expected none", fetch_pc_o);
            end else begin
                mon_r = req_q.pop_front();
                check("req_pc", fetch_pc_o, mon_r.pc);
                check("req_epoch", 64'(fetch_epoch_o), 64'(mon_r.ep));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hl;
        model_reset();
        @(posedge clk_i);
        #1;
        do_reset();

        // Boot cycle, then sequential fetches with one response per request.
        for (int i = 0; i < 5; i++) step(1, 0, '0, 0, '0, 0, auto_rsp(), 2'd0);
        check("p1_pc_10", fetch_pc_o, 64'h8000_0010);

        // Predicted-taken fetch, low bits of prediction dropped.
        step(1, 1, 64'h8000_0203, 0, '0, 0, auto_rsp(), 2'd0);
        check("p2_pred_pc", fetch_pc_o, 64'h8000_0200);

        // Back-pressure: PC held while not ready, prediction toggling.
        step(1, 0, '0, 1, 64'h8000_0020, 0, auto_rsp(), 2'd0);
        for (int i = 0; i < 3; i++)
            step(0, i[0], 64'({$urandom(), $urandom()}), 0, '0, 0, auto_rsp(), 2'd1);
        check("p3_hold_pc", fetch_pc_o, 64'h8000_0020);
        step(1, 0, '0, 0, '0, 0, 0, 2'd1);
        check("p3_adv_pc", fetch_pc_o, 64'h8000_0024);

        // Fill to the outstanding limit, then release one slot.
        for (int i = 0; i < 8 && m_out < MAX_OUT; i++) step(1, 0, '0, 0, '0, 0, 0, 2'd1);
        step(1, 0, '0, 0, '0, 0, 0, 2'd1);
        step(1, 0, '0, 0, '0, 0, 1, 2'd1);
        step(1, 0, '0, 0, '0, 0, 0, 2'd1);
        step(1, 0, '0, 0, '0, 0, 1, 2'd1);
        step(1, 0, '0, 0, '0, 0, 1, 2'd1);

        // Redirect with two old-epoch fetches in flight; their responses are dropped.
        for (int i = 0; i < 8 && m_out > 2; i++) step(0, 0, '0, 0, '0, 0, 1, 2'd1);
        step(1, 0, '0, 1, 64'h8000_1000, 0, 0, 2'd1);
        check("p5_redir_pc", fetch_pc_o, 64'h8000_1000);
        check("p5_redir_ep", 64'(fetch_epoch_o), 64'd2);
        step(1, 0, '0, 0, '0, 0, 1, 2'd1);
        step(1, 0, '0, 0, '0, 0, 1, 2'd1);
        step(1, 0, '0, 0, '0, 0, 1, 2'd2);

        // Redirect while halting; nothing issues until halt drops.
        step(1, 0, '0, 1, 64'h8000_3001, 1, 0, 2'd0);
        check("p6_halt_pc", fetch_pc_o, 64'h8000_3000);
        check("p6_halt_ep", 64'(fetch_epoch_o), 64'd3);
        for (int i = 0; i < 3; i++) step(1, 0, '0, 0, '0, 1, auto_rsp(), 2'd3);
        for (int i = 0; i < 3; i++) step(1, 0, '0, 0, '0, 0, auto_rsp(), 2'd3);

        // PC and epoch wrap-around.
        step(1, 0, '0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, auto_rsp(), 2'd3);
        check("wrap_epoch", 64'(fetch_epoch_o), 64'd0);
        step(1, 0, '0, 0, '0, 0, auto_rsp(), 2'd0);
        check("wrap_pc", fetch_pc_o, 64'd0);

        // Reset mid-burst, with a redirect attempted during the boot cycle.
        do_reset();
        step(1, 0, '0, 1, 64'h1234_0000, 0, 0, 2'd0);
        step(1, 0, '0, 0, '0, 0, 0, 2'd0);
        check("boot_redir_ignored", fetch_pc_o, RV + 64'd4);

        // Randomised traffic with occasional resets.
        hl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit rs;
            logic [1:0] rse;
            if (i % 700 == 699) do_reset();
            if ($urandom_range(0, 9) == 0) hl = ~hl;
            rs  = (m_out > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            rse = 2'(m_epoch - int'($urandom_range(0, 1)));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 64'({$urandom(), $urandom()}), $urandom_range(0, 15) == 0,
                 64'({$urandom(), $urandom()}), hl, rs, rse);
        end

        @(negedge clk_i);
        check("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
        check("req_q_drained", 64'(req_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
